debounce_tick: RTL and testbench
================================

DEBOUNCE_TICK -- requirements
Module: debounce_tick

Interface
REQ-001 SHALL have parameter STABLE_TICKS, default 4: consecutive tick strobes the synchronized input must stay stable before a level change is accepted; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle sample strobe from the upstream parameterized timer's done output.
REQ-005 SHALL have port sw_in  input  1  raw, asynchronous, bouncing switch level.
REQ-006 SHALL have port db_level  output  1  debounced level, registered.
REQ-007 SHALL have port db_rise  output  1  one-cycle pulse on an accepted 0->1 change, registered.
REQ-008 SHALL have port db_fall  output  1  one-cycle pulse on an accepted 1->0 change, registered.
REQ-009 SHALL have port busy  output  1  high while a candidate change is being qualified (WAIT1/WAIT0).

Function
REQ-010 SHALL synchronize sw_in through two flops (sync_in); sync_in lags sw_in by 2 cycles.
REQ-011 SHALL implement FSM states ZERO, WAIT1, ONE, WAIT0 and a tick counter cnt, width $clog2(STABLE_TICKS), minimum 1 bit.
REQ-012 ZERO: sync_in=1 -> WAIT1 with cnt=0; otherwise stay in ZERO.
REQ-013 WAIT1: sync_in=0 -> ZERO (bounce, no pulse); else on tick with cnt=STABLE_TICKS-1 -> ONE; else on tick cnt+1; no tick -> hold.
REQ-014 ONE/WAIT0 SHALL mirror REQ-012/013 with levels inverted; WAIT0 bounce returns to ONE.
REQ-015 When sync_in reverts in the same cycle as a tick, the revert SHALL win: no count, no acceptance.
REQ-016 db_level SHALL be 1 in ONE and WAIT0, 0 in ZERO and WAIT1; it updates in the same cycle the FSM enters ONE or ZERO.
REQ-017 db_rise SHALL be high exactly in the first cycle in ONE after a WAIT1->ONE transition; db_fall likewise for WAIT0->ZERO; rise and fall SHALL never be high together.
REQ-018 Qualification time SHALL be between STABLE_TICKS-1 and STABLE_TICKS tick periods, because the first tick may land mid-period; documented behaviour, not a defect.
REQ-019 cnt SHALL never exceed STABLE_TICKS-1 and SHALL NOT wrap.
REQ-020 With tick held constantly high, the block SHALL accept after STABLE_TICKS stable cycles.

Reset
REQ-021 On reset: sync flops=0, state=ZERO, cnt=0, db_level=0, db_rise=0, db_fall=0, busy=0 on the next clk edge.
REQ-022 Reset mid-qualification SHALL abandon the candidate without a pulse.
REQ-023 If sw_in is high when reset releases, the block SHALL qualify normally and emit one db_rise.

Structure
REQ-024 State encoding (ZERO=0, WAIT1=1, ONE=2, WAIT0=3) SHALL live in shared package debounce_pkg.
REQ-025 The two-flop synchronizer SHALL be a sub-module named sync_2ff; the FSM, counter and outputs stay in debounce_tick.

Verification (STABLE_TICKS=4, tick every 10 cycles unless stated)
REQ-026 Reset with sw_in=0 for 5 cycles -> all outputs 0; FSM in ZERO.
REQ-027 sw_in 0->1, held 80 cycles -> busy high from cycle 3; exactly one db_rise at the 4th tick seen in WAIT1; db_level=1 afterwards.
REQ-028 sw_in toggles every 3 cycles for 30 cycles, then holds 1 -> no db_rise during toggling; a single db_rise 4 ticks after the last toggle.
REQ-029 From ONE, sw_in 1->0, held -> exactly one db_fall; db_level=0; bouncing back inside WAIT0 returns to ONE with no pulse.
REQ-030 Reset asserted in WAIT1 after 2 ticks -> ZERO next edge; no db_rise; busy=0.
REQ-031 STABLE_TICKS=1, sync_in reverts in the same cycle as tick -> no acceptance (REQ-015); a clean hold -> db_rise on the first tick.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the tick-qualified switch debouncer.
// State encoding is fixed so waveform viewers and the bench agree on values.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // Counter width for 0..ticks-1, never narrower than one bit.
    function automatic int cnt_width(input int ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/debounce_tick_if.sv
// Bundles the debouncer's sample strobe, raw switch and qualified outputs.
// The master side drives stimulus; the slave side is the debouncer itself.
interface debounce_tick_if;

    logic tick;
    logic sw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;
    logic busy;

    modport master (
        output tick,
        output sw_in,
        input  db_level,
        input  db_rise,
        input  db_fall,
        input  busy
    );

    modport slave (
        input  tick,
        input  sw_in,
        output db_level,
        output db_rise,
        output db_fall,
        output busy
    );

endinterface

// File: rtl/debounce_tick_sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous switch into the clk domain.
// Output lags the input by two clock edges.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_tick.sv
// Switch debouncer: a level change is accepted only after the synchronized input
// stays stable for STABLE_TICKS sample strobes; a revert during qualification wins.
module debounce_tick
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall,
    output logic busy
);

    localparam int             CNT_W   = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync_in;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sync_in)
    );

    // The revert test comes before the tick test so a bounce coinciding with a strobe never counts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ZERO: begin
                if (sync_in) begin
                    state_next = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                if (!sync_in) begin
                    state_next = ZERO;
                end else if (tick) begin
                    if (cnt == CNT_MAX) state_next = ONE;
                    else                cnt_next   = cnt + CNT_W'(1);
                end
            end
            ONE: begin
                if (!sync_in) begin
                    state_next = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                if (sync_in) begin
                    state_next = ONE;
                end else if (tick) begin
                    if (cnt == CNT_MAX) state_next = ZERO;
                    else                cnt_next   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            db_level <= (state_next == ONE) || (state_next == WAIT0);
            db_rise  <= (state == WAIT1) && (state_next == ONE);
            db_fall  <= (state == WAIT0) && (state_next == ZERO);
            busy     <= (state_next == WAIT1) || (state_next == WAIT0);
        end
    end

endmodule

// File: tb/tb_debounce_tick.sv
// Bench for debounce_tick: a table of switch scenarios with expected pulse steps fed
// to a pulse scoreboard, plus a hand-written revert-versus-tick sequence at STABLE_TICKS=1.
module tb_debounce_tick;

    typedef struct {
        string name;
        int    pattern;
        bit    tick_const;
        int    n_steps;
        int    rise_step;
        int    fall_step;
        logic  end_level;
        int    busy_on;
    } vec_t;

    typedef struct {
        bit is_rise;
        int step;
    } pulse_t;

    logic   clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    bit     both_seen;
    pulse_t sb[$];
    vec_t   vecs[6];

    debounce_tick_if bus4 ();
    debounce_tick_if bus1 ();

    debounce_tick #(.STABLE_TICKS(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus4.tick),
        .sw_in    (bus4.sw_in),
        .db_level (bus4.db_level),
        .db_rise  (bus4.db_rise),
        .db_fall  (bus4.db_fall),
        .busy     (bus4.busy)
    );

    debounce_tick #(.STABLE_TICKS(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus1.tick),
        .sw_in    (bus1.sw_in),
        .db_level (bus1.db_level),
        .db_rise  (bus1.db_rise),
        .db_fall  (bus1.db_fall),
        .busy     (bus1.busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input int p, input bit tc, input int ns,
                                input int rs, input int fs, input logic lvl, input int bon);
        vec_t v;
        v.name = n; v.pattern = p; v.tick_const = tc; v.n_steps = ns;
        v.rise_step = rs; v.fall_step = fs; v.end_level = lvl; v.busy_on = bon;
        return v;
    endfunction

    // Switch waveform per scenario, indexed by step number starting at 1.
    function automatic void stim(input int pattern, input int s, output logic sw, output logic rst);
        rst = 1'b0;
        case (pattern)
            0: sw = 1'b1;
            1: sw = (s <= 30) ? (((s - 1) / 3) % 2 == 0) : 1'b1;
            2: sw = (s <= 50) || (s >= 66 && s <= 85);
            3: begin
                sw  = 1'b1;
                rst = (s == 26) || (s == 27);
            end
            default: sw = 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkPulse(input string vname, input int s);
        pulse_t p;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s unexpected_pulse: rise=%b fall=%b at step %0d, none expected",
                     vname, bus4.db_rise, bus4.db_fall, s);
        end else begin
            p = sb.pop_front();
            if (p.is_rise != bus4.db_rise || p.step != s) begin
                errors++;
                $display("[TB] FAIL %s pulse: got rise=%b at step %0d expected rise=%b at step %0d",
                         vname, bus4.db_rise, s, p.is_rise, p.step);
            end
        end
    endtask

    task automatic applyStimulus(input string vname, input logic sw, input logic tk,
                                 input logic rst, input int s);
        reset      = rst;
        bus4.sw_in = sw;
        bus4.tick  = tk;
        @(posedge clk);
        #1;
        if (bus4.db_rise || bus4.db_fall) checkPulse(vname, s);
        if (bus4.db_rise && bus4.db_fall) both_seen = 1'b1;
    endtask

    task automatic stepOne(input logic sw, input logic tk);
        reset      = 1'b0;
        bus1.sw_in = sw;
        bus1.tick  = tk;
        bus4.sw_in = 1'b0;
        bus4.tick  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input string vname);
        bus1.sw_in = 1'b0;
        bus1.tick  = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(vname, 1'b0, 1'b0, 1'b1, 0);
        checkOutput({vname, " reset level"}, bus4.db_level, 1'b0);
        checkOutput({vname, " reset rise"},  bus4.db_rise,  1'b0);
        checkOutput({vname, " reset fall"},  bus4.db_fall,  1'b0);
        checkOutput({vname, " reset busy"},  bus4.busy,     1'b0);
        checkOutput({vname, " reset dut1 level"}, bus1.db_level, 1'b0);
    endtask

    initial begin
        logic sw;
        logic rst;
        logic tk;
        logic exp_lvl;
        int   rise1;
        pulse_t p;

        reset      = 1'b1;
        bus4.sw_in = 1'b0;
        bus4.tick  = 1'b0;
        bus1.sw_in = 1'b0;
        bus1.tick  = 1'b0;

        // Ticks fall on every step that is a multiple of 10 unless tick_const is set.
        vecs[0] = mk("rise_hold",   0, 1'b0,  80, 40,  -1, 1'b1,  3);
        vecs[1] = mk("toggle",      1, 1'b0,  80, 70,  -1, 1'b1,  3);
        vecs[2] = mk("fall_bounce", 2, 1'b0, 150, 40, 120, 1'b0,  3);
        vecs[3] = mk("reset_wait1", 3, 1'b0,  80, 70,  -1, 1'b1,  3);
        vecs[4] = mk("tick_const",  0, 1'b1,  20,  7,  -1, 1'b1,  3);
        vecs[5] = mk("stay_low",    4, 1'b0,  30, -1,  -1, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            resetDut(v.name);
            sb.delete();
            both_seen = 1'b0;
            if (v.rise_step > 0) begin
                p.is_rise = 1'b1; p.step = v.rise_step; sb.push_back(p);
            end
            if (v.fall_step > 0) begin
                p.is_rise = 1'b0; p.step = v.fall_step; sb.push_back(p);
            end
            for (int s = 1; s <= v.n_steps; s++) begin
                stim(v.pattern, s, sw, rst);
                tk = v.tick_const ? 1'b1 : (s % 10 == 0);
                applyStimulus(v.name, sw, tk, rst, s);
                exp_lvl = (v.rise_step > 0) && (s >= v.rise_step) &&
                          ((v.fall_step < 0) || (s < v.fall_step));
                checkOutput($sformatf("%s level step %0d", v.name, s), bus4.db_level, exp_lvl);
                if (rst) begin
                    checkOutput($sformatf("%s busy in reset step %0d", v.name, s), bus4.busy, 1'b0);
                    checkOutput($sformatf("%s rise in reset step %0d", v.name, s), bus4.db_rise, 1'b0);
                end
                if (s == v.busy_on - 1)
                    checkOutput($sformatf("%s busy before step %0d", v.name, s), bus4.busy, 1'b0);
                if (s == v.busy_on)
                    checkOutput($sformatf("%s busy onset step %0d", v.name, s), bus4.busy, 1'b1);
            end
            checkOutput({v.name, " missing_pulse"}, sb.size() == 0, 1'b1);
            checkOutput({v.name, " rise_fall_together"}, both_seen, 1'b0);
            checkOutput({v.name, " end busy"}, bus4.busy, 1'b0);
            checkOutput({v.name, " end level"}, bus4.db_level, v.end_level);
        end

        // STABLE_TICKS=1: a revert landing on the tick must not accept; a clean hold accepts on the first tick.
        resetDut("st1");
        rise1 = 0;
        for (int s = 1; s <= 30; s++) begin
            stepOne((s <= 3) || (s >= 10), (s == 6) || (s == 20));
            if (bus1.db_rise) rise1++;
            if (s == 5)  checkOutput("st1 busy before revert", bus1.busy, 1'b1);
            if (s == 6) begin
                checkOutput("st1 revert level", bus1.db_level, 1'b0);
                checkOutput("st1 revert busy",  bus1.busy,     1'b0);
                checkOutput("st1 revert no rise", rise1 == 0,  1'b1);
            end
            if (s == 19) checkOutput("st1 busy before tick", bus1.busy, 1'b1);
            if (s == 20) begin
                checkOutput("st1 rise on first tick", bus1.db_rise,  1'b1);
                checkOutput("st1 level on accept",    bus1.db_level, 1'b1);
            end
            if (s == 21) checkOutput("st1 rise one cycle", bus1.db_rise, 1'b0);
        end
        checkOutput("st1 single rise", rise1 == 1, 1'b1);
        checkOutput("st1 no fall", bus1.db_fall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
